// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Field layout of the instruction frame (MSB first): op_code, reg_r, reg_w, data.
package fetch_unit_pkg;

  localparam int W     = 4;
  localparam int FRAME = 4 * W;

  localparam int OP_LO = 3 * W;
  localparam int RR_LO = 2 * W;
  localparam int RW_LO = 1 * W;
  localparam int D_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_e;

  function automatic logic [W-1:0] frame_field(input logic [FRAME-1:0] frame, input int lo);
    return frame[lo +: W];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side instruction interface of the fetch stage.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1. While instr_valid=1 and instr_ready=0 the master
  // holds op_code/reg_r/reg_w/data/instr_pc stable; instr_valid never depends
  // combinationally on instr_ready.
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] op_code;
  logic [W-1:0] reg_r;
  logic [W-1:0] reg_w;
  logic [W-1:0] data;
  logic [W-1:0] instr_pc;

  modport master (
    output instr_valid, op_code, reg_r, reg_w, data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, op_code, reg_r, reg_w, data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit_pc.sv
// Program counter: load (jump) beats increment beats hold.
// wrap flags an increment from the all-ones address back to zero.
module fetch_pc
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_addr,
  input  logic         inc,
  output logic [W-1:0] pc,
  output logic         wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

  assign wrap = inc && !load && (pc == {W{1'b1}});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory, presents
// instructions to decode. Optional FETCH_WRAP_HALT_EN halts instead of wrapping.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic             mem_en,
  output logic [W-1:0]     mem_addr,
  input  logic [FRAME-1:0] mem_data_frame,
  fetch_unit_if.master     dec,
  input  logic             jump_en,
  input  logic [W-1:0]     jump_addr,
  input  logic             halt_req,
  output logic             halted,
  output fetch_state_e     state_dbg
);

`ifdef FETCH_WRAP_HALT_EN
  localparam bit WRAP_HALT = 1'b1;
`else
  localparam bit WRAP_HALT = 1'b0;
`endif

  fetch_state_e     state, state_next;
  logic             halt_pend, halt_pend_next;
  logic [FRAME-1:0] ir;
  logic [W-1:0]     instr_pc_q;
  logic [W-1:0]     pc;
  logic             pc_load, pc_inc, pc_wrap;
  logic             capture;
  logic             go_halt;

  fetch_pc u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc),
    .wrap      (pc_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      halt_pend  <= 1'b0;
      ir         <= '0;
      instr_pc_q <= '0;
    end else begin
      state     <= state_next;
      halt_pend <= halt_pend_next;
      if (capture) begin
        ir         <= mem_data_frame;
        instr_pc_q <= pc;
      end
    end
  end

  always_comb begin
    state_next     = state;
    halt_pend_next = halt_pend | halt_req;
    pc_load        = 1'b0;
    pc_inc         = 1'b0;
    capture        = 1'b0;
    // Once halted, the stale pending flag must not block the exit jump.
    go_halt        = (state == S_HALT) ? halt_req : (halt_req | halt_pend);

    if (jump_en && (state != S_IDLE)) begin
      // Redirect discards any in-flight fetch and any unaccepted instruction.
      pc_load    = 1'b1;
      state_next = go_halt ? S_HALT : S_FETCH;
      if (!go_halt) begin
        halt_pend_next = 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE:  state_next = S_FETCH;
        S_FETCH: state_next = S_WAIT;
        S_WAIT: begin
          capture    = 1'b1;
          pc_inc     = 1'b1;
          state_next = S_VALID;
          if (WRAP_HALT && pc_wrap) begin
            halt_pend_next = 1'b1;
          end
        end
        S_VALID: begin
          if (dec.instr_ready) begin
            state_next = go_halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  state_next = S_HALT;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign mem_en          = (state == S_FETCH);
  assign mem_addr        = pc;
  assign halted          = (state == S_HALT);
  assign state_dbg       = state;

  assign dec.instr_valid = (state == S_VALID);
  assign dec.op_code     = frame_field(ir, OP_LO);
  assign dec.reg_r       = frame_field(ir, RR_LO);
  assign dec.reg_w       = frame_field(ir, RW_LO);
  assign dec.data        = frame_field(ir, D_LO);
  assign dec.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered program-memory model and a
// handshake scoreboard. Build with +define+FETCH_WRAP_HALT_EN for the wrap-halt variant.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and memory ----------------
  logic             mem_en;
  logic [W-1:0]     mem_addr;
  logic [FRAME-1:0] mem_data_frame = '0;
  logic             jump_en = 1'b0;
  logic [W-1:0]     jump_addr = '0;
  logic             halt_req = 1'b0;
  logic             halted;
  fetch_state_e     state_dbg;

  fetch_unit_if dec();

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_data_frame (mem_data_frame),
    .dec            (dec),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .halt_req       (halt_req),
    .halted         (halted),
    .state_dbg      (state_dbg)
  );

  logic [FRAME-1:0] rom [16] = '{
    16'h1F05, 16'h2E16, 16'h3D27, 16'h4C38, 16'h5B49, 16'h6A5A, 16'h796B, 16'h887C,
    16'h978D, 16'hA69E, 16'hB5AF, 16'hC4B0, 16'hD3C1, 16'hE2D2, 16'hF1E3, 16'h00F4
  };

  always @(posedge clk) begin
    if (mem_en) mem_data_frame <= rom[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W+FRAME-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_instr(input int addr);
    logic [W-1:0] a;
    a = W'(addr);
    exp_q.push_back({a, rom[a]});
  endtask

  always @(negedge clk) begin
    if (dec.instr_valid && dec.instr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", 32'({dec.instr_pc, dec.op_code}), 32'hFFFF_FFFF);
      end else begin
        check("handshake", 32'({dec.instr_pc, dec.op_code, dec.reg_r, dec.reg_w, dec.data}),
              32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fetch(input int addr);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_en) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("fetch_timeout", 32'(cyc), 32'(addr));
    else       check("fetch_addr", 32'(mem_addr), 32'(addr));
  endtask

  task automatic wait_valid(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dec.instr_valid) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check("valid_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic wait_halted();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted) begin
        seen = 1'b1;
        break;
      end
    end
    check("halted_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("halt_mem_en", 32'(mem_en), 32'd0);
      check("halt_valid", 32'(dec.instr_valid), 32'd0);
      check("halt_state", 32'(state_dbg), 32'(S_HALT));
      @(negedge clk);
    end
  endtask

  task automatic do_jump(input int addr);
    @(posedge clk); #1;
    jump_en   = 1'b1;
    jump_addr = W'(addr);
    halt_req  = 1'b0;
    @(posedge clk); #1;
    jump_en   = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_valid"}, 32'(dec.instr_valid), 32'd0);
    check({tag, "_fields"}, 32'({dec.op_code, dec.reg_r, dec.reg_w, dec.data}), 32'd0);
    check({tag, "_instr_pc"}, 32'(dec.instr_pc), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1, c2;
    dec.instr_ready = 1'b1;

    // Reset values, then release: first instr_valid 3 cycles later, then every 3rd cycle.
    repeat (2) @(negedge clk);
    check_outputs_zero("rst");
    for (int a = 0; a < 4; a++) push_instr(a);
    @(posedge clk); #1;
    rst_n = 1'b1;
    c0 = cyc;
    wait_valid(c1);
    check("first_latency", 32'(c1 - c0), 32'd3);
    wait_valid(c2);
    check("throughput_1", 32'(c2 - c1), 32'd3);
    wait_valid(c1);
    check("throughput_2", 32'(c1 - c2), 32'd3);
    wait_fetch(3);

    // Backpressure on instr_pc=3: fields stable, no fetch, resume at 4.
    @(posedge clk); #1;
    dec.instr_ready = 1'b0;
    wait_valid(c1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(dec.instr_valid), 32'd1);
      check("bp_frame", 32'({dec.op_code, dec.reg_r, dec.reg_w, dec.data}), 32'(rom[3]));
      check("bp_instr_pc", 32'(dec.instr_pc), 32'd3);
      check("bp_mem_en", 32'(mem_en), 32'd0);
      @(posedge clk);
    end
    #1;
    dec.instr_ready = 1'b1;
    wait_fetch(4);

    // Asynchronous reset while instr 4 is held in S_VALID.
    @(posedge clk); #1;
    dec.instr_ready = 1'b0;
    wait_valid(c1);
    check("bp4_instr_pc", 32'(dec.instr_pc), 32'd4);
    check("queue_drained_1", 32'(exp_q.size()), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dec.instr_ready = 1'b1;

    // Refetch from 0; jump to 9 during S_WAIT of addr 2; run through 15 and wrap.
    push_instr(0);
    push_instr(1);
    for (int a = 9; a < 16; a++) push_instr(a);
    for (int a = 0; a < 6; a++) push_instr(a);
    wait_fetch(0);
    wait_fetch(1);
    wait_fetch(2);
    do_jump(9);
    for (int a = 9; a < 16; a++) wait_fetch(a);
`ifdef FETCH_WRAP_HALT_EN
    wait_halted();
    do_jump(0);
`endif
    for (int a = 0; a < 6; a++) wait_fetch(a);

    // Halt pulse during S_FETCH of addr 5: instr 5 still handshaken, then halted.
    halt_req = 1'b1;
    @(posedge clk); #1;
    halt_req = 1'b0;
    wait_halted();
    check("halt_queue_drained", 32'(exp_q.size()), 32'd0);

    // Resume from halt via jump to 0.
    push_instr(0);
    push_instr(1);
    do_jump(0);
    wait_fetch(0);
    check("resume_halted", 32'(halted), 32'd0);
    wait_fetch(1);
    wait_fetch(2);
    @(posedge clk); #1;
    dec.instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
